// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div_pkg                                                       |
// | Purpose  : Shared types and helpers for the unary divider source stage.  |
// |            - state_t     : source FSM states                             |
// |            - lfsr_taps() : Fibonacci feedback mask, BW 3..10             |
// |            - bitrev()    : van der Corput bit reversal of a BW-bit value |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package div_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int C_MAX_BW = 10;

   // Feedback mask for a shift-left Fibonacci LFSR; bit k set means
   // state[k] is XORed into the new LSB. Each mask is a primitive polynomial.
   function automatic logic [C_MAX_BW-1:0] lfsr_taps(input int bw);
      logic [C_MAX_BW-1:0] m;
      case (bw)
         3:       m = 10'h006;
         4:       m = 10'h00C;
         5:       m = 10'h014;
         6:       m = 10'h030;
         7:       m = 10'h060;
         8:       m = 10'h0B8;
         9:       m = 10'h110;
         10:      m = 10'h240;
         default: m = 10'h014;
      endcase
      return m;
   endfunction

   // Reverse the low bw bits of value; upper bits of the result are zero.
   function automatic logic [C_MAX_BW-1:0] bitrev(input logic [C_MAX_BW-1:0] value,
                                                  input int bw);
      logic [C_MAX_BW-1:0] r;
      r = '0;
      for (int i = 0; i < C_MAX_BW; i++) begin
         if (i < bw) r[i] = value[bw-1-i];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sng_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sng_lfsr                                                      |
// | Purpose  : BW-bit maximal-length Fibonacci LFSR (period 2^BW-1) with a   |
// |            synchronous seed load and an advance enable.                  |
// | Ports    : clk      - clock, rising edge                                 |
// |            rst      - asynchronous reset, active-high (state <- seed)    |
// |            ld_i     - load seed this edge (priority over en_i)           |
// |            en_i     - advance one step this edge                         |
// |            state_o  - current LFSR state                                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sng_lfsr
   import div_pkg::*;
#(
   parameter int BW   = 5,
   parameter int SEED = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_i,
   input  logic          en_i,
   output logic [BW-1:0] state_o
);

   localparam logic [C_MAX_BW-1:0] C_TAPS_FULL = lfsr_taps(BW);
   localparam logic [BW-1:0]       C_TAPS      = C_TAPS_FULL[BW-1:0];
   localparam logic [BW-1:0]       C_SEED_RAW  = BW'(SEED);
   // An all-zero state would lock the register, so a zero seed becomes 1.
   localparam logic [BW-1:0]       C_SEED      = (C_SEED_RAW == '0) ? BW'(1) : C_SEED_RAW;

   logic [BW-1:0] lfsr_q;
   logic          w_fb;

   assign w_fb    = ^(lfsr_q & C_TAPS);
   assign state_o = lfsr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= C_SEED;
      end else if (ld_i) begin
         lfsr_q <= C_SEED;
      end else if (en_i) begin
         lfsr_q <= {lfsr_q[BW-2:0], w_fb};
      end
   end

endmodule
`default_nettype wire

// File: rtl/div_sng_src.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div_sng_src                                                   |
// | Purpose  : Source stage for the unary divider. Latches a dividend and    |
// |            divisor, then emits 2^BW cycles of dividend/divisor bits      |
// |            (exact one-counts) plus an LFSR random number.                |
// | Option   : DIV_SNG_CLIP_EN - clip the latched dividend to the divisor.   |
// | Ports    : clk, rst (async, active-high)                                 |
// |            load_valid/load_ready, dividend_bin, divisor_bin - load side  |
// |            out_valid, dividend, divisor, randNum, last, div0 - stream    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module div_sng_src
   import div_pkg::*;
#(
   parameter int BW   = 5,
   parameter int SEED = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [BW-1:0] dividend_bin,
   input  logic [BW-1:0] divisor_bin,
   output logic          out_valid,
   output logic          dividend,
   output logic          divisor,
   output logic [BW-1:0] randNum,
   output logic          last,
   output logic          div0
);

   state_t        state_q;
   logic [BW-1:0] cnt_q;
   logic [BW-1:0] dvd_q;
   logic [BW-1:0] dvd_d;
   logic [BW-1:0] dsr_q;
   logic          div0_q;
   logic          w_run;
   logic          w_last;
   logic          w_accept;
   logic [BW-1:0] w_rev;
   logic [BW-1:0] w_lfsr;

   assign w_run    = (state_q == RUN);
   assign w_last   = w_run && (cnt_q == '1);
   assign w_accept = load_valid && load_ready;
   // Bit-reversed count decorrelates the divisor stream from the dividend's.
   assign w_rev    = BW'(bitrev(C_MAX_BW'(cnt_q), BW));

   always_comb begin
      dvd_d = dividend_bin;
`ifdef DIV_SNG_CLIP_EN
      if (dividend_bin > divisor_bin) dvd_d = divisor_bin;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         div0_q  <= 1'b0;
      end else if (w_accept) begin
         state_q <= RUN;
         cnt_q   <= '0;
         dvd_q   <= dvd_d;
         dsr_q   <= divisor_bin;
         div0_q  <= (divisor_bin == '0);
      end else if (w_run) begin
         cnt_q <= cnt_q + BW'(1);
         if (w_last) state_q <= IDLE;
      end
   end

   sng_lfsr #(
      .BW   (BW),
      .SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .ld_i    (w_accept),
      .en_i    (w_run),
      .state_o (w_lfsr)
   );

   assign load_ready = !w_run || w_last;
   assign out_valid  = w_run;
   assign last       = w_last;
   assign dividend   = w_run && (dvd_q > cnt_q);
   assign divisor    = w_run && (dsr_q > w_rev);
   assign randNum    = w_lfsr;
   assign div0       = div0_q;

endmodule
`default_nettype wire

// File: doc/div_sng_src.md
Name: div_sng_src

Overview:
- Upstream source stage for the unary divider.
- Accepts a binary dividend/divisor pair through a valid/ready load handshake, then emits one full stream of 2^BW cycles containing:
  - a dividend bitstream and a divisor bitstream, generated from decorrelated low-discrepancy sources;
  - a third, uncorrelated random number that the divider uses for its quotient comparator.
- Feeds the divider's dividend, divisor and randNum inputs directly.

Parameters:
- BW, 5, operand and random-number width; stream length is 2^BW cycles; legal range 3..10.
- SEED, 1, initial LFSR state for randNum; a value of 0 is forced to 1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- load_valid  input  1  operand pair presented
- load_ready  output  1  block can accept a new pair this cycle
- dividend_bin  input  BW  unsigned dividend value
- divisor_bin  input  BW  unsigned divisor value
- out_valid  output  1  stream bits valid this cycle
- dividend  output  1  dividend bitstream
- divisor  output  1  divisor bitstream
- randNum  output  BW  random number for the divider quotient comparator
- last  output  1  final cycle of the current stream
- div0  output  1  latched divisor_bin==0 for the current stream

Behaviour:
- Reset (rst=1, asynchronous, any state):
  - state←IDLE; cnt←0; lfsr←SEED (0 is forced to 1); operand registers←0; div0←0.
  - Output values during reset: load_ready=1, out_valid=0, last=0, dividend=0, divisor=0, randNum=SEED.
  - Reset asserted mid-stream abandons the stream; no partial completion.
- States:
  - IDLE: load_ready=1; out_valid=0; dividend and divisor forced 0; lfsr holds.
  - RUN: out_valid=1.
- Load accept (load_valid & load_ready at a rising edge):
  - Latch dvd_q←dividend_bin and dsr_q←divisor_bin.
  - div0←(divisor_bin==0).
  - cnt←0; lfsr←SEED; state←RUN.
  - Latency: the first stream bit appears in the cycle after the accept.
- RUN, every cycle:
  - dividend = (dvd_q > cnt); divisor = (dsr_q > bitrev(cnt)), where bitrev is the van der Corput bit reversal.
  - randNum = lfsr.
  - At each edge: cnt←cnt+1 and lfsr advances.
- Exactness: over the 2^BW cycles of a stream, the number of ones equals dvd_q on dividend and dsr_q on divisor, exactly.
- LFSR: BW-bit Fibonacci, maximal length (period 2^BW−1), taps taken from the package table; never reaches 0.
- Stream end:
  - last = RUN & (cnt == all-ones); load_ready is also 1 in RUN while last=1.
  - last cycle with load accepted: new operands latched, cnt←0, lfsr←SEED, remain in RUN (back-to-back, zero bubble).
  - last cycle with no load: cnt wraps to 0; state←IDLE.
- load_valid while RUN and not last: ignored (load_ready=0); the source must hold its data.
- Combinational outputs depend only on registers; no input-to-output combinational path.

Optional Feature:
- Macro: DIV_SNG_CLIP_EN.
- Defined: at load accept, dvd_q←min(dividend_bin, divisor_bin), so the quotient stream stays in [0,1].
- Not defined: dvd_q←dividend_bin unmodified; the downstream divider saturates on its own.
- div0 behaviour is identical in both builds.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, RUN};
  - function lfsr_taps(BW) returning the tap mask for BW 3..10;
  - function bitrev(value, BW).
- One sub-module, sng_lfsr: BW-bit maximal LFSR with synchronous load of the seed, enable, and asynchronous active-high reset.
- Counter, comparators and FSM stay in div_sng_src.

Test Plan:
- BW=5; load dividend_bin=12, divisor_bin=20 → out_valid high for 32 cycles; dividend totals 12 ones and divisor totals 20 ones; last=1 only in cycle 32; then load_ready=1 and out_valid=0.
- BW=5; randNum sampled over the first 31 RUN cycles after a load → 31 distinct nonzero values; cycle 32 repeats the cycle-1 value (= SEED).
- Load 5/7, then keep load_valid high with 9/30 → second stream starts the cycle after last with no gap; counts are 9 and 30; mid-stream load_valid is ignored.
- rst pulsed at cycle 10 of a stream → outputs immediately take reset values (out_valid=0, randNum=SEED); a new load 3/4 then yields exactly 3 and 4 ones.
- Load dividend_bin=25, divisor_bin=10:
  - with DIV_SNG_CLIP_EN → dividend has 10 ones;
  - without the macro → dividend has 25 ones.
- Load divisor_bin=0 → div0=1 for the whole stream and divisor is all zeros; the next load with divisor_bin=6 clears div0.
